// File: rtl/lfsr_pkg.sv
// Shared constants, mode enum and Galois step function for the 16-bit LFSR stepper.
package lfsr_pkg;
  localparam int unsigned LFSR_W = 16;
  localparam logic [LFSR_W-1:0] DEF_TAPS = 16'hB400;
  localparam logic [LFSR_W-1:0] DEF_SEED = 16'hACE1;

  typedef enum logic {PAUSE, RUN} mode_e;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v,
                                                   input logic [LFSR_W-1:0] taps);
    lfsr_step = v[0] ? ((v >> 1) ^ taps) : (v >> 1);
  endfunction
endpackage

// File: rtl/step_tick_gen.sv
// Divide-by-DIV tick generator; counter held at zero while disabled or cleared.
module step_tick_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = en_i && (cnt_q == LAST);
    cnt_d  = cnt_q + CW'(1);
    if (clr_i || !en_i || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/lfsr16_stepper.sv
// 16-bit Galois LFSR with run/pause stepping, seed load and zero-seed guard.
// Optional period checker built when LFSR_PERIOD_CHECK_EN is defined.
module lfsr16_stepper
  import lfsr_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned STEP_HZ = 2,
  parameter logic [15:0] SEED    = DEF_SEED,
  parameter logic [15:0] TAPS    = DEF_TAPS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        load,
  input  logic [15:0] seed_in,
  output logic [15:0] value,
  output logic        step_pulse,
  output logic        seed_err
`ifdef LFSR_PERIOD_CHECK_EN
  ,
  output logic [15:0] period_cnt,
  output logic        period_ok
`endif
);
  localparam int unsigned DIV = CLK_HZ / STEP_HZ;

  mode_e       state_q, state_d;
  logic [15:0] value_q, value_d, load_val, next_val;
  logic        pulse_q, pulse_d, err_q, err_d;
  logic        sync1_q, sync2_q, prev_q, evt_q;
  logic        tick, do_step;

  step_tick_gen #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .en_i   (state_q == RUN),
    .clr_i  (load),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      PAUSE:   if (run_sw)  state_d = RUN;
      RUN:     if (!run_sw) state_d = PAUSE;
      default: state_d = PAUSE;
    endcase
  end

  // Edge event is registered so a press sampled at edge k lands at edge k+3.
  always_comb begin
    load_val = (seed_in != '0) ? seed_in : SEED;
    next_val = lfsr_step(value_q, TAPS);
    do_step  = !load && (tick || (evt_q && (state_q == PAUSE)));
    value_d  = value_q;
    err_d    = err_q;
    pulse_d  = 1'b0;
    if (load) begin
      value_d = load_val;
      err_d   = (seed_in == '0);
    end else if (do_step) begin
      value_d = next_val;
      pulse_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PAUSE;
      value_q <= SEED;
      pulse_q <= 1'b0;
      err_q   <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      evt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      pulse_q <= pulse_d;
      err_q   <= err_d;
      sync1_q <= step_btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      evt_q   <= sync2_q & ~prev_q;
    end
  end

  assign value      = value_q;
  assign step_pulse = pulse_q;
  assign seed_err   = err_q;

`ifdef LFSR_PERIOD_CHECK_EN
  logic [15:0] pcnt_q, pcnt_d, start_q, start_d;
  logic        pok_q, pok_d;

  always_comb begin
    pcnt_d  = pcnt_q;
    start_d = start_q;
    pok_d   = pok_q;
    if (load) begin
      pcnt_d  = '0;
      start_d = load_val;
      pok_d   = 1'b0;
    end else if (do_step) begin
      pcnt_d = (pcnt_q == '1) ? pcnt_q : pcnt_q + 16'd1;
      if ((next_val == start_q) && (pcnt_d == '1)) pok_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q  <= '0;
      start_q <= SEED;
      pok_q   <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      start_q <= start_d;
      pok_q   <= pok_d;
    end
  end

  assign period_cnt = pcnt_q;
  assign period_ok  = pok_q;
`endif
endmodule

// File: tb/tb_lfsr16_stepper.sv
// Scoreboard bench for lfsr16_stepper; expected step values are queued and
// matched against each step_pulse by a monitor.
module tb_lfsr16_stepper;
  localparam int unsigned CLK_HZ = 10;
`ifdef LFSR_PERIOD_CHECK_EN
  localparam int unsigned STEP_HZ = 5;
`else
  localparam int unsigned STEP_HZ = 1;
`endif
  localparam int unsigned DIV = CLK_HZ / STEP_HZ;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run_sw = 1'b0;
  logic        step_btn = 1'b0;
  logic        load = 1'b0;
  logic [15:0] seed_in = '0;
  logic [15:0] value;
  logic        step_pulse;
  logic        seed_err;
`ifdef LFSR_PERIOD_CHECK_EN
  logic [15:0] period_cnt;
  logic        period_ok;
`endif

  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;
  int checks = 0;
  int passes = 0;
  int pulses = 0;

  lfsr16_stepper #(.CLK_HZ(CLK_HZ), .STEP_HZ(STEP_HZ), .SEED(16'hACE1), .TAPS(16'hB400)) dut (
    .clk        (clk),
    .rst        (rst),
    .run_sw     (run_sw),
    .step_btn   (step_btn),
    .load       (load),
    .seed_in    (seed_in),
    .value      (value),
    .step_pulse (step_pulse),
    .seed_err   (seed_err)
`ifdef LFSR_PERIOD_CHECK_EN
    ,
    .period_cnt (period_cnt),
    .period_ok  (period_ok)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_next(input logic [15:0] v);
    logic [15:0] r;
    r = {1'b0, v[15:1]};
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && step_pulse) begin
      pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_step value=%h expected no step", value);
      end else begin
        mon_exp = exp_q.pop_front();
        if (value !== mon_exp) $display("FAIL step_value got=%h exp=%h", value, mon_exp);
        else passes++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    checks++; if (value !== 16'hACE1) $display("FAIL rst_value got=%h exp=%h", value, 16'hACE1); else passes++;
    checks++; if (step_pulse !== 1'b0) $display("FAIL rst_pulse got=%b exp=0", step_pulse); else passes++;
    checks++; if (seed_err !== 1'b0) $display("FAIL rst_seed_err got=%b exp=0", seed_err); else passes++;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    checks++; if (value !== 16'hACE1) $display("FAIL post_rst_value got=%h exp=%h", value, 16'hACE1); else passes++;
    checks++; if (step_pulse !== 1'b0) $display("FAIL post_rst_pulse got=%b exp=0", step_pulse); else passes++;
    checks++; if (seed_err !== 1'b0) $display("FAIL post_rst_seed_err got=%b exp=0", seed_err); else passes++;
  endtask

  task automatic test_manual_step;
    logic [15:0] req [2];
    logic [15:0] cur;
    logic [5:0]  pat;
    int          p0;
    req[0] = 16'hE270;
    req[1] = 16'h7138;
    cur = 16'hACE1;
    run_sw = 1'b0;
    cyc(2);
    for (int k = 0; k < 2; k++) begin
      cur = model_next(cur);
      exp_q.push_back(cur);
      p0 = pulses;
      step_btn = 1'b1;
      for (int i = 0; i < 6; i++) begin
        cyc(1);
        pat[i] = step_pulse;
      end
      cyc(44);
      step_btn = 1'b0;
      cyc(5);
      checks++; if (pat !== 6'b001000) $display("FAIL manual_timing got=%b exp=%b", pat, 6'b001000); else passes++;
      checks++; if (pulses - p0 != 1) $display("FAIL manual_held_once got=%0d exp=1", pulses - p0); else passes++;
      checks++; if (value !== req[k]) $display("FAIL manual_value got=%h exp=%h", value, req[k]); else passes++;
    end
    checks++; if (exp_q.size() != 0) $display("FAIL manual_queue left=%0d exp=0", exp_q.size()); else passes++;
  endtask

  task automatic test_auto_run;
    logic [15:0] cur;
    int          pc [3];
    int          n;
    int          p0;
    cur = value;
    for (int k = 0; k < 3; k++) begin
      cur = model_next(cur);
      exp_q.push_back(cur);
    end
    n = 0;
    run_sw = 1'b1;
    for (int c = 1; c <= 3 * DIV + 1; c++) begin
      step_btn = (c <= 2 * DIV - 2) ? c[0] : 1'b0;
      cyc(1);
      if (step_pulse === 1'b1) begin
        if (n < 3) pc[n] = c;
        n++;
      end
    end
    run_sw = 1'b0;
    step_btn = 1'b0;
    checks++; if (n != 3) $display("FAIL auto_count got=%0d exp=3", n); else passes++;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (k >= n || pc[k] != (k + 1) * DIV + 1)
        $display("FAIL auto_period idx=%0d got=%0d exp=%0d", k, (k < n) ? pc[k] : -1, (k + 1) * DIV + 1);
      else passes++;
    end
    p0 = pulses;
    cyc(3 * DIV);
    checks++; if (value !== cur) $display("FAIL pause_freeze got=%h exp=%h", value, cur); else passes++;
    checks++; if (pulses != p0) $display("FAIL pause_no_step got=%0d exp=%0d", pulses, p0); else passes++;
  endtask

  task automatic test_load;
    int first;
    load = 1'b1; seed_in = 16'h0001;
    cyc(1);
    load = 1'b0;
    checks++; if (value !== 16'h0001) $display("FAIL load_value got=%h exp=%h", value, 16'h0001); else passes++;
    checks++; if (step_pulse !== 1'b0) $display("FAIL load_pulse got=%b exp=0", step_pulse); else passes++;
    checks++; if (seed_err !== 1'b0) $display("FAIL load_err got=%b exp=0", seed_err); else passes++;
    exp_q.push_back(model_next(16'h0001));
    step_btn = 1'b1;
    cyc(2);
    step_btn = 1'b0;
    cyc(6);
    checks++; if (value !== 16'hB400) $display("FAIL load_then_step got=%h exp=%h", value, 16'hB400); else passes++;

    load = 1'b1; seed_in = 16'h0000;
    cyc(1);
    load = 1'b0;
    checks++; if (value !== 16'hACE1) $display("FAIL zero_seed_value got=%h exp=%h", value, 16'hACE1); else passes++;
    checks++; if (seed_err !== 1'b1) $display("FAIL zero_seed_err got=%b exp=1", seed_err); else passes++;
    cyc(3);
    checks++; if (seed_err !== 1'b1) $display("FAIL seed_err_sticky got=%b exp=1", seed_err); else passes++;
    load = 1'b1; seed_in = 16'h5A5A;
    cyc(1);
    load = 1'b0;
    checks++; if (seed_err !== 1'b0) $display("FAIL seed_err_clear got=%b exp=0", seed_err); else passes++;

    run_sw = 1'b1;
    cyc(DIV);
    load = 1'b1; seed_in = 16'h1234;
    cyc(1);
    load = 1'b0;
    checks++; if (value !== 16'h1234) $display("FAIL load_vs_tick_value got=%h exp=%h", value, 16'h1234); else passes++;
    checks++; if (step_pulse !== 1'b0) $display("FAIL load_vs_tick_pulse got=%b exp=0", step_pulse); else passes++;
    exp_q.push_back(model_next(16'h1234));
    first = 0;
    for (int j = 1; j <= DIV + 2 && first == 0; j++) begin
      cyc(1);
      if (step_pulse === 1'b1) first = j;
    end
    run_sw = 1'b0;
    checks++; if (first != DIV) $display("FAIL load_counter_clear got=%0d exp=%0d", first, DIV); else passes++;
    cyc(3);
    checks++; if (exp_q.size() != 0) $display("FAIL load_queue left=%0d exp=0", exp_q.size()); else passes++;
  endtask

  task automatic test_reset_mid_run;
    int p0;
    run_sw = 1'b1;
    cyc(DIV / 2 + 1);
    step_btn = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++; if (value !== 16'hACE1) $display("FAIL midrun_rst_value got=%h exp=%h", value, 16'hACE1); else passes++;
    checks++; if (step_pulse !== 1'b0) $display("FAIL midrun_rst_pulse got=%b exp=0", step_pulse); else passes++;
    cyc(1);
    run_sw = 1'b0;
    step_btn = 1'b0;
    cyc(1);
    rst = 1'b0;
    p0 = pulses;
    cyc(3 * DIV + 5);
    checks++; if (value !== 16'hACE1) $display("FAIL midrun_after_value got=%h exp=%h", value, 16'hACE1); else passes++;
    checks++; if (pulses != p0) $display("FAIL midrun_no_step got=%0d exp=%0d", pulses, p0); else passes++;
  endtask

`ifdef LFSR_PERIOD_CHECK_EN
  task automatic test_period;
    logic [15:0] cur;
    int          budget;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    checks++; if (period_cnt !== 16'h0000) $display("FAIL period_cnt_rst got=%h exp=0000", period_cnt); else passes++;
    checks++; if (period_ok !== 1'b0) $display("FAIL period_ok_rst got=%b exp=0", period_ok); else passes++;
    cur = 16'hACE1;
    for (int k = 0; k < 65535; k++) begin
      cur = model_next(cur);
      exp_q.push_back(cur);
    end
    run_sw = 1'b1;
    budget = 65535 * DIV + 100;
    while (exp_q.size() != 0 && budget > 0) begin
      cyc(1);
      budget--;
    end
    run_sw = 1'b0;
    checks++; if (budget == 0) $display("FAIL period_timeout left=%0d exp=0", exp_q.size()); else passes++;
    checks++; if (value !== 16'hACE1) $display("FAIL period_value got=%h exp=%h", value, 16'hACE1); else passes++;
    checks++; if (period_cnt !== 16'hFFFF) $display("FAIL period_cnt got=%h exp=%h", period_cnt, 16'hFFFF); else passes++;
    checks++; if (period_ok !== 1'b1) $display("FAIL period_ok got=%b exp=1", period_ok); else passes++;
    exp_q.delete();
  endtask
`endif

  initial begin
`ifdef LFSR_PERIOD_CHECK_EN
    #5000000;
`else
    #200000;
`endif
    $display("FAIL watchdog_timeout checks=%0d passed=%0d", checks, passes);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_manual_step();
    test_auto_run();
    test_load();
    test_reset_mid_run();
`ifdef LFSR_PERIOD_CHECK_EN
    test_period();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/lfsr16_stepper.md
Name: lfsr16_stepper

Overview:
- 16-bit Galois LFSR pattern source for the DE2-115 LFSR_16bit design.
- Sits directly upstream of the four per-nibble hex-digit seven-segment decoders; value[15:12]..value[3:0] feed HEX3..HEX0.
- Run mode: steps automatically at a divided rate. Pause mode: single-steps on a key press. Also supports seed load and a zero-lockup guard.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- STEP_HZ, 2, auto-step rate in run mode; DIV = CLK_HZ/STEP_HZ, must be >= 2.
- SEED, 16'hACE1, reset value and substitute for an illegal zero seed.
- TAPS, 16'hB400, Galois feedback mask for x^16+x^14+x^13+x^11+1.

Ports:
- clk  in  1  system clock (CLOCK_50 at top).
- rst  in  1  asynchronous, active-high reset.
- run_sw  in  1  1 = auto-run, 0 = pause (synchronous level, from a switch).
- step_btn  in  1  manual step request, active-high; top inverts KEY; asynchronous to clk.
- load  in  1  synchronous one-cycle seed-load strobe.
- seed_in  in  16  seed sampled when load = 1.
- value  out  16  current LFSR state.
- step_pulse  out  1  high for the one cycle in which value shows a newly stepped state.
- seed_err  out  1  sticky: the last load presented zero.

Behaviour:
- Reset (async assert, sync release): value = SEED; step_pulse = 0; seed_err = 0; tick counter = 0; sync flops = 0; state = PAUSE.
- Step function: if value[0] = 1, next = (value >> 1) ^ TAPS; otherwise next = value >> 1. The all-zero state is unreachable.
- FSM states:
  - PAUSE -> RUN when run_sw = 1.
  - RUN -> PAUSE when run_sw = 0.
  - State is registered; the mode change takes effect on the cycle after run_sw is sampled.
- Tick divider:
  - Counter runs 0..DIV-1 in RUN only; tick when counter == DIV-1, then wraps to 0.
  - Counter is held at 0 in PAUSE, so the first auto-step comes DIV cycles after entering RUN.
- Manual step:
  - step_btn passes through a 2-flop synchronizer plus a previous-value flop.
  - step_evt = sync2 & ~prev.
  - step_evt is honoured only in PAUSE; in RUN it is discarded.
  - A rising edge sampled at edge k updates value at edge k+3.
  - Holding the button gives exactly one step.
- Load:
  - load has highest priority: value <= (seed_in != 0) ? seed_in : SEED.
  - seed_err <= (seed_in == 0).
  - A tick or step_evt in the same cycle is dropped.
  - The tick counter resets to 0.
  - step_pulse stays 0 for a load.
- step_pulse is registered and asserts on the same edge at which a step (tick or manual) updates value.
- Reset mid-step: any pending sync/edge state is cleared and no step is emitted after release.
- Output latency to the displays: value is registered; the downstream decoders are combinational.

Optional Feature:
- Macro: LFSR_PERIOD_CHECK_EN.
- With the macro defined:
  - Extra outputs: period_cnt[15:0] and period_ok (1 bit).
  - period_cnt counts steps since the last load/reset and saturates at 16'hFFFF.
  - Start value is captured at load/reset.
  - period_ok is set when value returns to the start value with period_cnt == 65535, and cleared by load/reset.
  - If the state returns with any other count, period_ok stays 0.
- Without the macro: neither port exists and no counter logic is built.

Decomposition:
- Package lfsr_pkg: LFSR_W = 16, default TAPS and SEED constants, state enum {PAUSE, RUN}.
- One sub-module: step_tick_gen (parameterised DIV, enable input, tick output, counter clear on load).
- Synchronizer/edge detect stays inline.

Test Plan:
- Reset check: rst pulse -> value = 16'hACE1, step_pulse = 0, seed_err = 0 during and after reset.
- Manual step: PAUSE, two step_btn presses -> value 16'hE270 then 16'h7138; each step_pulse lasts 1 cycle, 3 cycles after the synchronized edge; a button held 50 cycles gives one step only.
- Auto-run (CLK_HZ = 10, STEP_HZ = 1):
  - run_sw = 1 -> steps every 10 cycles.
  - Toggling step_btn in RUN has no effect.
  - run_sw = 0 freezes value.
- Load:
  - load with seed_in = 16'h0001 -> value = 16'h0001; next step gives 16'hB400.
  - load with seed_in = 0 -> value = 16'hACE1 and seed_err = 1.
  - load coincident with a tick -> no step, no step_pulse.
- Async reset mid-run: assert rst between clock edges during RUN -> value = 16'hACE1 immediately; state = PAUSE after release.
- With LFSR_PERIOD_CHECK_EN, DIV = 2: run 65535 steps from the SEED -> value = 16'hACE1, period_cnt = 65535, period_ok = 1.
